branch_checkpoint_buffer: RTL and testbench
===========================================

BRANCH_CHECKPOINT_BUFFER -- requirements
Module: branch_checkpoint_buffer

Interface
REQ-001 The block SHALL use shared-package constants: BRANCH_NUM, default 4, number of checkpoint slots; BRANCH_NUM_INDEX, default 2, slot index width; ACTIVE_LIST_SIZE_INDEX, default 5, active-list id width; PHYS_REG_NUM_INDEX, default 6, physical-register index width; REG_NUM, default 32, architectural register count; GHR_LEN, default 8, global history length.
REQ-002 The block SHALL use one clock; reset is synchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst_n  in  1  synchronous active-low reset.
REQ-005 alloc_valid  in  1  renamed branch requests a checkpoint this cycle.
REQ-006 alloc_ready  out  1  slot at write_pointer is free; alloc accepted iff alloc_valid && alloc_ready.
REQ-007 alloc_branch_id  in  ACTIVE_LIST_SIZE_INDEX  active-list id of the branch.
REQ-008 alloc_free_head  in  PHYS_REG_NUM_INDEX  free-list head snapshot.
REQ-009 alloc_ghr  in  GHR_LEN  GHR snapshot, including the predicted bit at [0].
REQ-010 alloc_rename_buffer  in  REG_NUM x PHYS_REG_NUM_INDEX  rename-map snapshot.
REQ-011 ds_renamed  in  1  delay slot of the most recently allocated branch is renamed.
REQ-012 resolve_valid / resolve_branch_id  in  1 / ACTIVE_LIST_SIZE_INDEX  branch resolved correctly; release its slot.
REQ-013 recover_valid  in  1  misprediction recovery pulse (hazard branch_miss).
REQ-014 recover_valid_mask / recover_write_pointer  in  BRANCH_NUM / BRANCH_NUM_INDEX  post-flush slot valids and write pointer from the misprediction handler.
REQ-015 curr_branch_state  branch_state_ifc.out  registered slot contents: valid, branch_id, free_head_pointer, GHR, rename_buffer, ds_valid, write_pointer.
REQ-016 occupancy  out  BRANCH_NUM_INDEX+1  count of valid slots.

Function
REQ-017 An accepted alloc SHALL write all snapshot fields into slot write_pointer, set valid=1 and ds_valid=0, and increment write_pointer modulo BRANCH_NUM on the next edge.
REQ-018 alloc_ready SHALL equal !valid[write_pointer] and depend only on registered state, with no combinational path from any input.
REQ-019 On wrap-around, write_pointer SHALL go from BRANCH_NUM-1 to 0.
REQ-020 resolve_valid SHALL clear valid of every valid slot whose branch_id equals resolve_branch_id on the next edge, and SHALL leave write_pointer unchanged.
REQ-021 ds_renamed SHALL set ds_valid of slot write_pointer-1 (mod BRANCH_NUM) if that slot is valid; otherwise ds_renamed SHALL be ignored.
REQ-022 If alloc and ds_renamed occur in the same cycle, ds_renamed SHALL apply to the older slot before the allocation takes effect.
REQ-023 recover_valid SHALL load valid from recover_valid_mask and write_pointer from recover_write_pointer.
REQ-024 recover_valid SHALL take priority over alloc, ds_renamed and resolve in the same cycle; the alloc is dropped and the upstream stage replays it.
REQ-025 A resolve and an accepted alloc targeting different slots in the same cycle SHALL both take effect.
REQ-026 A slot freed by resolve SHALL NOT be reusable by an alloc in the same cycle.
REQ-027 A resolve_branch_id matching no valid slot SHALL have no effect.
REQ-028 occupancy SHALL equal the popcount of registered valid; full is indicated by occupancy==BRANCH_NUM.
REQ-029 Snapshot fields of invalid slots are don't-care, but SHALL be held when no write occurs.

Reset
REQ-030 While rst_n=0 at a clock edge: valid=0, ds_valid=0, write_pointer=0, occupancy=0, alloc_ready=1.
REQ-031 Snapshot arrays SHALL NOT require reset.
REQ-032 Reset SHALL override all inputs, including a simultaneous recover_valid.

Structure
REQ-033 All width constants and branch_state_ifc SHALL reside in the shared package/interface file with the other pipeline interfaces.
REQ-034 One sub-module SHALL be instantiated: popcount for occupancy.
REQ-035 The block SHALL be a single register array with a small next-state always_comb.

Verification
REQ-036 Reset, then 4 allocs with ids 3,4,5,6 -> valid=4'b1111, write_pointer=0, alloc_ready=0, occupancy=4.
REQ-037 Full, then resolve id 4 -> the following cycle valid=4'b1101, alloc_ready=0 (pointer at slot 0); resolve id 3 -> alloc_ready=1, and the next alloc writes slot 0.
REQ-038 Alloc id 7 to slot 2, ds_renamed next cycle -> ds_valid[2]=1; a following alloc to slot 3 -> ds_valid[3]=0.
REQ-039 recover_valid with mask 4'b0011, pointer 2, alloc_valid=1 in the same cycle -> valid=4'b0011, write_pointer=2, no slot written.
REQ-040 Same-cycle alloc to slot 1 and resolve of slot 0 -> valid[1]=1, valid[0]=0, write_pointer=2.
REQ-041 rst_n=0 asserted mid-stream with recover_valid=1 -> all valid=0, write_pointer=0 after the edge.

Source files
------------

// File: rtl/branch_checkpoint_buffer_pkg.sv
// Shared pipeline constants, pointer helpers and the branch-state interface
// carried from the checkpoint buffer to the misprediction handler.
package branch_checkpoint_buffer_pkg;
  localparam int BRANCH_NUM             = 4;
  localparam int BRANCH_NUM_INDEX       = 2;
  localparam int ACTIVE_LIST_SIZE_INDEX = 5;
  localparam int PHYS_REG_NUM_INDEX     = 6;
  localparam int REG_NUM                = 32;
  localparam int GHR_LEN                = 8;

  typedef logic [BRANCH_NUM_INDEX-1:0] slot_ptr_t;

  function automatic slot_ptr_t ptr_inc(input slot_ptr_t p);
    return (p == slot_ptr_t'(BRANCH_NUM - 1)) ? '0 : p + slot_ptr_t'(1);
  endfunction

  function automatic slot_ptr_t ptr_dec(input slot_ptr_t p);
    return (p == '0) ? slot_ptr_t'(BRANCH_NUM - 1) : p - slot_ptr_t'(1);
  endfunction
endpackage

interface branch_state_ifc;
  import branch_checkpoint_buffer_pkg::*;

  logic [BRANCH_NUM-1:0]                                      valid;
  logic [BRANCH_NUM-1:0][ACTIVE_LIST_SIZE_INDEX-1:0]          branch_id;
  logic [BRANCH_NUM-1:0][PHYS_REG_NUM_INDEX-1:0]              free_head_pointer;
  logic [BRANCH_NUM-1:0][GHR_LEN-1:0]                         ghr;
  logic [BRANCH_NUM-1:0][REG_NUM-1:0][PHYS_REG_NUM_INDEX-1:0] rename_buffer;
  logic [BRANCH_NUM-1:0]                                      ds_valid;
  logic [BRANCH_NUM_INDEX-1:0]                                write_pointer;

  modport out (output valid, branch_id, free_head_pointer, ghr, rename_buffer,
               ds_valid, write_pointer);
  modport in  (input  valid, branch_id, free_head_pointer, ghr, rename_buffer,
               ds_valid, write_pointer);
endinterface

// File: rtl/branch_checkpoint_buffer_popcount.sv
// Population count of a bit vector; used for checkpoint occupancy.
module branch_checkpoint_buffer_popcount #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CNT_W-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) count = count + CNT_W'(bits[i]);
  end
endmodule

// File: rtl/branch_checkpoint_buffer.sv
// Circular buffer of branch checkpoints (rename map, free-list head, GHR),
// allocated at rename, released on correct resolve, rewound on recovery.
module branch_checkpoint_buffer
  import branch_checkpoint_buffer_pkg::*;
(
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      alloc_valid,
  output logic                                      alloc_ready,
  input  logic [ACTIVE_LIST_SIZE_INDEX-1:0]         alloc_branch_id,
  input  logic [PHYS_REG_NUM_INDEX-1:0]             alloc_free_head,
  input  logic [GHR_LEN-1:0]                        alloc_ghr,
  input  logic [REG_NUM-1:0][PHYS_REG_NUM_INDEX-1:0] alloc_rename_buffer,
  input  logic                                      ds_renamed,
  input  logic                                      resolve_valid,
  input  logic [ACTIVE_LIST_SIZE_INDEX-1:0]         resolve_branch_id,
  input  logic                                      recover_valid,
  input  logic [BRANCH_NUM-1:0]                     recover_valid_mask,
  input  logic [BRANCH_NUM_INDEX-1:0]               recover_write_pointer,
  branch_state_ifc.out                              curr_branch_state,
  output logic [BRANCH_NUM_INDEX:0]                 occupancy
);
  logic [BRANCH_NUM-1:0]                                      valid_q, valid_d;
  logic [BRANCH_NUM-1:0]                                      ds_q, ds_d;
  slot_ptr_t                                                  wp_q, wp_d;
  logic [BRANCH_NUM-1:0][ACTIVE_LIST_SIZE_INDEX-1:0]          id_q;
  logic [BRANCH_NUM-1:0][PHYS_REG_NUM_INDEX-1:0]              head_q;
  logic [BRANCH_NUM-1:0][GHR_LEN-1:0]                         ghr_q;
  logic [BRANCH_NUM-1:0][REG_NUM-1:0][PHYS_REG_NUM_INDEX-1:0] map_q;
  logic                                                       alloc_fire;
  slot_ptr_t                                                  prev_ptr;

  // Readiness comes from registered state only, so no input reaches it.
  assign alloc_ready = ~valid_q[wp_q];
  assign alloc_fire  = alloc_valid & alloc_ready & ~recover_valid;
  assign prev_ptr    = ptr_dec(wp_q);

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    valid_d = valid_q;
    ds_d    = ds_q;
    wp_d    = wp_q;
    if (recover_valid) begin
      valid_d = recover_valid_mask;
      wp_d    = recover_write_pointer;
    end else begin
      if (resolve_valid)
        for (int i = 0; i < BRANCH_NUM; i++)
          if (valid_q[i] && id_q[i] == resolve_branch_id) valid_d[i] = 1'b0;
      // Delay slot belongs to the older branch, applied before this alloc.
      if (ds_renamed && valid_q[prev_ptr]) ds_d[prev_ptr] = 1'b1;
      if (alloc_fire) begin
        valid_d[wp_q] = 1'b1;
        ds_d[wp_q]    = 1'b0;
        wp_d          = ptr_inc(wp_q);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      ds_q    <= '0;
      wp_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ds_q    <= ds_d;
      wp_q    <= wp_d;
    end
  end

  // NOTE: snapshot storage is not reset; it is only meaningful while valid.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      id_q[wp_q]   <= alloc_branch_id;
      head_q[wp_q] <= alloc_free_head;
      ghr_q[wp_q]  <= alloc_ghr;
      map_q[wp_q]  <= alloc_rename_buffer;
    end
  end

  assign curr_branch_state.valid             = valid_q;
  assign curr_branch_state.branch_id         = id_q;
  assign curr_branch_state.free_head_pointer = head_q;
  assign curr_branch_state.ghr               = ghr_q;
  assign curr_branch_state.rename_buffer     = map_q;
  assign curr_branch_state.ds_valid          = ds_q;
  assign curr_branch_state.write_pointer     = wp_q;

  branch_checkpoint_buffer_popcount #(
    .WIDTH (BRANCH_NUM),
    .CNT_W (BRANCH_NUM_INDEX + 1)
  ) u_popcount (
    .bits  (valid_q),
    .count (occupancy)
  );
endmodule

// File: tb/tb_branch_checkpoint_buffer.sv
// Directed bench for branch_checkpoint_buffer with hand-computed expectations.
module tb_branch_checkpoint_buffer;
  import branch_checkpoint_buffer_pkg::*;

  logic                                       clk = 1'b0;
  logic                                       rst_n;
  logic                                       alloc_valid;
  logic                                       alloc_ready;
  logic [ACTIVE_LIST_SIZE_INDEX-1:0]          alloc_branch_id;
  logic [PHYS_REG_NUM_INDEX-1:0]              alloc_free_head;
  logic [GHR_LEN-1:0]                         alloc_ghr;
  logic [REG_NUM-1:0][PHYS_REG_NUM_INDEX-1:0] alloc_rename_buffer;
  logic                                       ds_renamed;
  logic                                       resolve_valid;
  logic [ACTIVE_LIST_SIZE_INDEX-1:0]          resolve_branch_id;
  logic                                       recover_valid;
  logic [BRANCH_NUM-1:0]                      recover_valid_mask;
  logic [BRANCH_NUM_INDEX-1:0]                recover_write_pointer;
  logic [BRANCH_NUM_INDEX:0]                  occupancy;

  branch_state_ifc st ();

  branch_checkpoint_buffer dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .alloc_valid           (alloc_valid),
    .alloc_ready           (alloc_ready),
    .alloc_branch_id       (alloc_branch_id),
    .alloc_free_head       (alloc_free_head),
    .alloc_ghr             (alloc_ghr),
    .alloc_rename_buffer   (alloc_rename_buffer),
    .ds_renamed            (ds_renamed),
    .resolve_valid         (resolve_valid),
    .resolve_branch_id     (resolve_branch_id),
    .recover_valid         (recover_valid),
    .recover_valid_mask    (recover_valid_mask),
    .recover_write_pointer (recover_write_pointer),
    .curr_branch_state     (st),
    .occupancy             (occupancy)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Snapshot payload derived from the id so slot contents are recognisable.
  task automatic set_alloc(input logic v, input int id);
    alloc_valid     = v;
    alloc_branch_id = ACTIVE_LIST_SIZE_INDEX'(id);
    alloc_free_head = PHYS_REG_NUM_INDEX'(id + 10);
    alloc_ghr       = GHR_LEN'(id * 3);
    for (int r = 0; r < REG_NUM; r++)
      alloc_rename_buffer[r] = PHYS_REG_NUM_INDEX'(id + r);
  endtask

  task automatic idle();
    set_alloc(1'b0, 0);
    ds_renamed    = 1'b0;
    resolve_valid = 1'b0;
    recover_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    resolve_branch_id     = '0;
    recover_valid_mask    = '0;
    recover_write_pointer = '0;
    step(); step();
    check("rst_valid", st.valid, 4'b0000);
    check("rst_ds", st.ds_valid, 4'b0000);
    check("rst_wp", st.write_pointer, 0);
    check("rst_occ", occupancy, 0);
    check("rst_ready", alloc_ready, 1);
    rst_n = 1'b1;

    // Fill all four slots with ids 3..6
    for (int id = 3; id <= 6; id++) begin
      set_alloc(1'b1, id);
      step();
    end
    idle();
    check("full_valid", st.valid, 4'b1111);
    check("full_wp", st.write_pointer, 0);
    check("full_ready", alloc_ready, 0);
    check("full_occ", occupancy, 4);
    check("slot1_id", st.branch_id[1], 4);
    check("slot1_head", st.free_head_pointer[1], 14);
    check("slot3_ghr", st.ghr[3], 18);
    check("slot2_map5", st.rename_buffer[2][5], 10);

    // Alloc while full is refused
    set_alloc(1'b1, 15); step(); idle();
    check("full_drop_valid", st.valid, 4'b1111);
    check("full_drop_id0", st.branch_id[0], 3);
    check("full_drop_wp", st.write_pointer, 0);

    // Unknown id resolves nothing
    resolve_valid = 1'b1; resolve_branch_id = 20; step(); idle();
    check("res_none", st.valid, 4'b1111);

    resolve_valid = 1'b1; resolve_branch_id = 4; step(); idle();
    check("res4_valid", st.valid, 4'b1101);
    check("res4_ready", alloc_ready, 0);
    check("res4_occ", occupancy, 3);
    check("res4_wp", st.write_pointer, 0);
    resolve_valid = 1'b1; resolve_branch_id = 3; step(); idle();
    check("res3_valid", st.valid, 4'b1100);
    check("res3_ready", alloc_ready, 1);
    set_alloc(1'b1, 9); step(); idle();
    check("realloc_valid", st.valid, 4'b1101);
    check("realloc_id0", st.branch_id[0], 9);
    check("realloc_wp", st.write_pointer, 1);

    // Recovery beats a simultaneous alloc
    recover_valid = 1'b1; recover_valid_mask = 4'b0011; recover_write_pointer = 2;
    set_alloc(1'b1, 12); step(); idle();
    check("rec_valid", st.valid, 4'b0011);
    check("rec_wp", st.write_pointer, 2);
    check("rec_id2_kept", st.branch_id[2], 5);

    set_alloc(1'b1, 7); step(); idle();
    check("a7_valid", st.valid, 4'b0111);
    check("a7_ds2", st.ds_valid[2], 0);
    ds_renamed = 1'b1; step(); idle();
    check("ds2_set", st.ds_valid[2], 1);
    set_alloc(1'b1, 8); step(); idle();
    check("a8_ds3", st.ds_valid[3], 0);
    check("a8_ds2", st.ds_valid[2], 1);
    check("a8_wrap_wp", st.write_pointer, 0);

    // Same-cycle alloc to slot 1 and resolve of slot 0 (id 9)
    recover_valid = 1'b1; recover_valid_mask = 4'b0001; recover_write_pointer = 1;
    step(); idle();
    set_alloc(1'b1, 10); resolve_valid = 1'b1; resolve_branch_id = 9; step(); idle();
    check("ar_valid", st.valid, 4'b0010);
    check("ar_wp", st.write_pointer, 2);
    check("ar_id1", st.branch_id[1], 10);

    // Alloc with ds_renamed: delay slot marks the older slot 1
    set_alloc(1'b1, 11); ds_renamed = 1'b1; step(); idle();
    check("ads_ds", st.ds_valid, 4'b0010);
    check("ads_wp", st.write_pointer, 3);
    check("ads_valid", st.valid, 4'b0110);

    // ds_renamed ignored when the older slot is invalid
    recover_valid = 1'b1; recover_valid_mask = 4'b0000; recover_write_pointer = 0;
    step(); idle();
    ds_renamed = 1'b1; step(); idle();
    check("ds_ignored", st.ds_valid, 4'b0010);
    check("empty_occ", occupancy, 0);

    // Reset overrides a simultaneous recovery
    set_alloc(1'b1, 1); step(); idle();
    check("pre_rst_valid", st.valid, 4'b0001);
    rst_n = 1'b0; recover_valid = 1'b1; recover_valid_mask = 4'b1111;
    recover_write_pointer = 3;
    step(); idle();
    check("rst2_valid", st.valid, 4'b0000);
    check("rst2_wp", st.write_pointer, 0);
    check("rst2_ds", st.ds_valid, 4'b0000);
    check("rst2_ready", alloc_ready, 1);
    check("rst2_occ", occupancy, 0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
